// File: rtl/keyin_accumulator.sv
// keyin_accumulator
//   Collects keypad digits (encoded 4-bit code plus a "pressed" level) into an
//   NDIG-nibble value for the display block. Supports BCD and hex entry radix,
//   backspace and enter keys in BCD, auto-commit when a hex entry fills, and a
//   sticky overflow flag when a BCD entry is already full.
// Ports:
//   clk, rst (async, active low), clr (sync clear)
//   key_code[3:0], key_pressed : keypad interface (level, code stable while held)
//   op[1:0]                    : entry mode request (bit1: 0=BCD, 1=hex)
//   value_out[4*NDIG-1:0]      : accumulated value, newest digit in nibble 0
//   mode[1:0]                  : latched op
//   digit_cnt[CNT_W-1:0]       : digits currently held
//   overflow                   : sticky, BCD digit rejected because entry full
//   commit                     : one-cycle pulse when entry is committed
//   state[2:0]                 : 0 EMPTY, 1 ENTRY, 2 DONE, 3 ERR
module keyin_accumulator #(
  parameter int NDIG  = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [3:0]           key_code,
  input  logic                 key_pressed,
  input  logic [1:0]           op,
  output logic [4*NDIG-1:0]    value_out,
  output logic [1:0]           mode,
  output logic [CNT_W-1:0]     digit_cnt,
  output logic                 overflow,
  output logic                 commit,
  output logic [2:0]           state
);

  localparam int               VW      = 4 * NDIG;
  localparam logic [CNT_W-1:0] NDIG_C  = CNT_W'(NDIG);
  localparam logic             ONE_DIG = (NDIG == 1);

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_ENTRY = 3'd1,
    S_DONE  = 3'd2,
    S_ERR   = 3'd3
  } state_e;

  logic [VW-1:0]    value_q,   value_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       mode_q,    mode_d;
  logic             ov_q,      ov_d;
  logic             commit_q,  commit_d;
  logic             pressed_q, pressed_d;
  state_e           state_q,   state_d;

  // Key decode uses the latched mode, not the raw op request.
  logic          evt, hex, is_dig, is_bs, is_ent, cnt_next_full;
  logic [VW-1:0] val_shl, val_new;

  assign evt           = key_pressed & ~pressed_q;
  assign hex           = mode_q[1];
  assign is_dig        = hex | (key_code <= 4'd9);
  assign is_bs         = ~hex & (key_code == 4'hE);
  assign is_ent        = ~hex & (key_code == 4'hF);
  // Truncating casts keep the shift legal for NDIG == 1 as well.
  assign val_shl       = VW'({value_q, key_code});
  assign val_new       = VW'(key_code);
  assign cnt_next_full = ((cnt_q + 1'b1) == NDIG_C);

  always_comb begin
    value_d   = value_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    ov_d      = ov_q;
    commit_d  = 1'b0;
    state_d   = state_q;
    pressed_d = key_pressed;   // tracked even during clr so a held key stays dead

    if (clr) begin
      value_d = '0;
      cnt_d   = '0;
      ov_d    = 1'b0;
      state_d = S_EMPTY;
      mode_d  = op;
    end else begin
      case (state_q)
        S_EMPTY, S_ENTRY: begin
          if (state_q == S_EMPTY) mode_d = op;
          if (evt && is_dig) begin
            if (cnt_q < NDIG_C) begin
              value_d = val_shl;
              cnt_d   = cnt_q + 1'b1;
              state_d = S_ENTRY;
              // A full hex entry commits itself.
              if (hex && cnt_next_full) begin
                state_d  = S_DONE;
                commit_d = 1'b1;
              end
            end else if (!hex) begin
              ov_d    = 1'b1;
              state_d = S_ERR;
            end
          end else if (evt && is_bs && state_q == S_ENTRY) begin
            value_d = value_q >> 4;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = S_EMPTY;
          end else if (evt && is_ent && state_q == S_ENTRY) begin
            state_d  = S_DONE;
            commit_d = 1'b1;
          end
        end
        S_DONE: begin
          // Any digit starts a fresh entry; commands are ignored here.
          if (evt && is_dig) begin
            value_d = val_new;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            if (hex && ONE_DIG) begin
              state_d  = S_DONE;
              commit_d = 1'b1;
            end else begin
              state_d = S_ENTRY;
            end
          end
        end
        S_ERR: begin
          if (evt && is_bs) begin
            ov_d    = 1'b0;
            state_d = S_ENTRY;
          end
        end
        default: begin
          // Unused encodings recover exactly as a clear would.
          value_d = '0;
          cnt_d   = '0;
          ov_d    = 1'b0;
          state_d = S_EMPTY;
          mode_d  = op;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q   <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      ov_q      <= 1'b0;
      commit_q  <= 1'b0;
      pressed_q <= 1'b0;
      state_q   <= S_EMPTY;
    end else begin
      value_q   <= value_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      ov_q      <= ov_d;
      commit_q  <= commit_d;
      pressed_q <= pressed_d;
      state_q   <= state_d;
    end
  end

  assign value_out = value_q;
  assign digit_cnt = cnt_q;
  assign mode      = mode_q;
  assign overflow  = ov_q;
  assign commit    = commit_q;
  assign state     = state_q;

endmodule

// File: tb/tb_keyin_accumulator.sv
// Bench for keyin_accumulator (NDIG=4): directed scenarios followed by random
// key/clr/op traffic, compared against a digit-queue reference model.
module tb_keyin_accumulator;
  localparam int NDIG  = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic [3:0]       key_code = 4'h0;
  logic             key_pressed = 1'b0;
  logic [1:0]       op = 2'd0;
  logic [4*NDIG-1:0] value_out;
  logic [1:0]       mode;
  logic [CNT_W-1:0] digit_cnt;
  logic             overflow, commit;
  logic [2:0]       state;

  keyin_accumulator #(.NDIG(NDIG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .key_code(key_code),
    .key_pressed(key_pressed), .op(op), .value_out(value_out), .mode(mode),
    .digit_cnt(digit_cnt), .overflow(overflow), .commit(commit), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Commit pulse monitor.
  int   commit_seen = 0;
  int   commit_consec = 0;
  logic commit_prev = 1'b0;
  always @(negedge clk) begin
    if (commit === 1'b1) begin
      commit_seen <= commit_seen + 1;
      if (commit_prev) commit_consec <= commit_consec + 1;
    end
    commit_prev <= (commit === 1'b1);
  end

  // Reference model: entry held as a queue of digits, oldest first.
  int       mq[$];
  int       ms;        // 0 EMPTY, 1 ENTRY, 2 DONE, 3 ERR
  bit       mov;
  bit [1:0] mmode;
  int       mcommits;

  function automatic logic [31:0] m_value();
    logic [31:0] v = 0;
    foreach (mq[i]) v = (v << 4) | 32'(mq[i]);
    return v;
  endfunction

  task automatic m_clear();
    mq.delete(); ms = 0; mov = 0; mmode = op;
  endtask

  task automatic m_press(input int code);
    bit h = mmode[1];
    if (h || code <= 9) begin
      if (ms == 2) begin
        mq.delete(); mq.push_back(code); ms = 1;
        if (h && mq.size() == NDIG) begin ms = 2; mcommits++; end
      end else if (ms != 3) begin
        if (mq.size() < NDIG) begin
          mq.push_back(code); ms = 1;
          if (h && mq.size() == NDIG) begin ms = 2; mcommits++; end
        end else if (!h) begin
          mov = 1; ms = 3;
        end
      end
    end else if (code == 14) begin
      if (ms == 1) begin
        void'(mq.pop_back());
        if (mq.size() == 0) ms = 0;
      end else if (ms == 3) begin
        mov = 0; ms = 1;
      end
    end else if (code == 15) begin
      if (ms == 1) begin ms = 2; mcommits++; end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_val"},    32'(value_out), m_value());
    chk({tag, "_cnt"},    32'(digit_cnt), 32'(mq.size()));
    chk({tag, "_state"},  32'(state),     32'(ms));
    chk({tag, "_ovf"},    32'(overflow),  32'(mov));
    chk({tag, "_mode"},   32'(mode),      32'(mmode));
    chk({tag, "_commit"}, 32'(commit_seen), 32'(mcommits));
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int gap);
    key_code = code; key_pressed = 1'b1;
    step(1);
    m_press(int'(code));
    if (hold > 1) step(hold - 1);
    key_pressed = 1'b0;
    step(gap);
    if (ms == 0) mmode = op;
  endtask

  task automatic do_clr(input logic [1:0] new_op);
    op = new_op; clr = 1'b1;
    step(1);
    clr = 1'b0;
    m_clear();
    step(1);
  endtask

  task automatic set_op(input logic [1:0] new_op);
    op = new_op;
    step(1);
    if (ms == 0) mmode = op;
  endtask

  initial begin
    mq.delete(); ms = 0; mov = 0; mmode = 0; mcommits = 0;

    // Reset state
    #12;
    chk("rst_val", 32'(value_out), 0);
    chk("rst_cnt", 32'(digit_cnt), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_commit", 32'(commit), 0);
    chk("rst_mode", 32'(mode), 0);
    rst = 1'b1;
    step(2);

    // BCD entry 1,2,3 held long, then enter
    press(4'h1, 1000, 2); press(4'h2, 1000, 2); press(4'h3, 1000, 2);
    press(4'hF, 5, 2);
    chk("t1_val", 32'(value_out), 32'h0123);
    chk("t1_cnt", 32'(digit_cnt), 3);
    chk("t1_state", 32'(state), 2);
    chk("t1_commit", 32'(commit_seen), 1);
    chk_all("t1");

    // BCD overflow and backspace recovery
    for (int d = 1; d <= 5; d++) press(4'(d), 3, 2);
    chk("t2_val", 32'(value_out), 32'h1234);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_state", 32'(state), 3);
    press(4'hE, 2, 2);
    chk("t2_bs_ovf", 32'(overflow), 0);
    chk("t2_bs_state", 32'(state), 1);
    chk("t2_bs_val", 32'(value_out), 32'h1234);
    press(4'hE, 2, 2);
    chk("t2_bs2_val", 32'(value_out), 32'h0123);
    chk("t2_bs2_cnt", 32'(digit_cnt), 3);
    chk_all("t2");

    // Hex entry auto-commit, then new entry from DONE
    do_clr(2'd2);
    press(4'hA, 2, 1); press(4'hB, 2, 1); press(4'hC, 2, 1);
    chk("t3_pre_commit", 32'(commit_seen), 1);
    press(4'hD, 2, 1);
    chk("t3_val", 32'(value_out), 32'hABCD);
    chk("t3_state", 32'(state), 2);
    chk("t3_commit", 32'(commit_seen), 2);
    press(4'h7, 2, 1);
    chk("t3_new_val", 32'(value_out), 32'h0007);
    chk("t3_new_cnt", 32'(digit_cnt), 1);
    chk("t3_new_state", 32'(state), 1);
    chk_all("t3");

    // Long hold with clr and a key toggle inside the clr window
    do_clr(2'd0);
    key_code = 4'h5; key_pressed = 1'b1;
    step(1); m_press(5);
    step(500);
    clr = 1'b1; m_clear();
    step(2);
    key_pressed = 1'b0; step(1);
    key_pressed = 1'b1; step(1);
    clr = 1'b0;
    step(2000);
    chk("t4_val", 32'(value_out), 0);
    chk("t4_cnt", 32'(digit_cnt), 0);
    chk_all("t4");
    key_pressed = 1'b0; step(2);
    press(4'h9, 3, 2);
    chk("t4_repress", 32'(value_out), 32'h0009);

    // clr with op change mid-entry; op ignored once in ENTRY
    do_clr(2'd0);
    press(4'h1, 2, 1); press(4'h2, 2, 1);
    chk("t5_pre", 32'(value_out), 32'h0012);
    do_clr(2'd2);
    chk("t5_val", 32'(value_out), 0);
    chk("t5_state", 32'(state), 0);
    chk("t5_mode", 32'(mode), 2);
    press(4'h3, 2, 1);
    set_op(2'd0); step(3);
    chk("t5_mode_hold", 32'(mode), 2);
    chk_all("t5");

    // Async reset between edges
    do_clr(2'd0);
    press(4'h4, 2, 1); press(4'h5, 2, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t6_val", 32'(value_out), 0);
    chk("t6_cnt", 32'(digit_cnt), 0);
    chk("t6_state", 32'(state), 0);
    chk("t6_mode", 32'(mode), 0);
    mq.delete(); ms = 0; mov = 0; mmode = 0;
    step(2);
    rst = 1'b1;
    step(2);
    mmode = op;
    press(4'h9, 2, 2);
    chk("t6_after", 32'(value_out), 32'h0009);
    chk_all("t6");

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      do_clr(2'($urandom_range(0, 3)));
      else if (r <= 2) set_op(2'($urandom_range(0, 3)));
      else press(4'($urandom_range(0, 15)), $urandom_range(1, 4), $urandom_range(1, 3));
      chk_all("rnd");
    end

    chk("commit_no_consec", 32'(commit_consec), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
